// File: rtl/pxeboot_flash_rdrsp.sv
// Flash-side Avalon-MM burst-read responder: splits one burst into single-word memory
// reads and returns all-ones for words outside the OptionROM window. Optional macro: PXEBOOT_FLASH_RDRSP_TIMEOUT_EN.
module pxeboot_flash_rdrsp #(
    parameter int          FLASH_ADDR_WIDTH = 28,
    parameter logic [31:0] WIN_BADDR        = 32'h0B80_0000,
    parameter int          WIN_SIZE_KB      = 32,
    parameter int          MAX_BURST        = 64,
    parameter int          TIMEOUT_CYC      = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [FLASH_ADDR_WIDTH-1:0] avmm_slv_addr,
    input  logic                        avmm_slv_read,
    input  logic [6:0]                  avmm_slv_burstcnt,
    output logic [31:0]                 avmm_slv_rddata,
    output logic                        avmm_slv_rddvld,
    output logic                        avmm_slv_waitreq,
    output logic                        mem_rd_req,
    output logic [FLASH_ADDR_WIDTH-3:0] mem_rd_addr,
    input  logic                        mem_rd_ack,
    input  logic [31:0]                 mem_rd_data,
    input  logic                        status_clr,
    output logic [31:0]                 rsp_status
);
    localparam int          WA_W    = FLASH_ADDR_WIDTH - 2;
    localparam int          WIN_WSH = $clog2(WIN_SIZE_KB * 256);
    localparam int          WIN_BSH = $clog2(WIN_SIZE_KB * 1024);
    localparam logic [31:0] WIN_TAG = WIN_BADDR >> WIN_BSH;

    typedef enum logic [1:0] {IDLE, MEM_RD, FILL} state_t;

    function automatic logic f_in_win(input logic [WA_W-1:0] wa);
        logic [31:0] w;
        w = 32'(wa);
        return (w >> WIN_WSH) == WIN_TAG;
    endfunction

    state_t            r_state;
    logic [WA_W-1:0]   r_waddr;
    logic [6:0]        r_remain;
    logic [31:0]       r_rddata;
    logic              r_rddvld;
    logic              r_req;
    logic              r_bad, r_tmo, r_oow;
    logic [15:0]       r_beats;

    logic              w_accept, w_bad, w_ack, w_tmo, w_last, w_next_in, w_unused;
    logic [6:0]        w_cnt;
    logic [WA_W-1:0]   w_cmd_wa, w_next_wa;

    assign avmm_slv_waitreq = reset | (r_state != IDLE);
    assign w_accept  = avmm_slv_read & ~avmm_slv_waitreq;
    assign w_cmd_wa  = avmm_slv_addr[FLASH_ADDR_WIDTH-1:2];
    assign w_bad     = (avmm_slv_burstcnt == 7'd0) || (avmm_slv_burstcnt > 7'(MAX_BURST));
    assign w_cnt     = (avmm_slv_burstcnt == 7'd0)          ? 7'd1 :
                       (avmm_slv_burstcnt > 7'(MAX_BURST))  ? 7'(MAX_BURST) : avmm_slv_burstcnt;
    assign w_next_wa = r_waddr + WA_W'(1);
    assign w_next_in = f_in_win(w_next_wa);
    assign w_last    = (r_remain == 7'd1);
    assign w_ack     = r_req & mem_rd_ack;

`ifdef PXEBOOT_FLASH_RDRSP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo_cnt;

    // Timeout fires in the TIMEOUT_CYC-th unacknowledged cycle; a same-cycle ack wins.
    assign w_tmo    = r_req & ~mem_rd_ack & (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_unused = ^avmm_slv_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset || !r_req || mem_rd_ack || w_tmo) r_tmo_cnt <= '0;
        else                                         r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
`else
    assign w_tmo    = 1'b0;
    assign w_unused = ^{avmm_slv_addr[1:0], 1'(TIMEOUT_CYC)};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_waddr  <= '0;
            r_remain <= '0;
            r_rddata <= '0;
            r_rddvld <= 1'b0;
            r_req    <= 1'b0;
        end else begin
            r_rddvld <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_waddr  <= w_cmd_wa;
                    r_remain <= w_cnt;
                    r_req    <= f_in_win(w_cmd_wa);
                    r_state  <= f_in_win(w_cmd_wa) ? MEM_RD : FILL;
                end
                MEM_RD: if (w_ack || w_tmo) begin
                    r_rddvld <= 1'b1;
                    r_rddata <= w_ack ? mem_rd_data : 32'hFFFF_FFFF;
                    r_remain <= r_remain - 7'd1;
                    if (w_last) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end else begin
                        r_waddr <= w_next_wa;
                        r_state <= w_next_in ? MEM_RD : FILL;
                        // After a timeout the request drops for one cycle before relaunching.
                        r_req   <= w_next_in & w_ack;
                    end
                end else if (!r_req) begin
                    r_req <= 1'b1;
                end
                FILL: begin
                    r_rddvld <= 1'b1;
                    r_rddata <= 32'hFFFF_FFFF;
                    r_remain <= r_remain - 7'd1;
                    if (w_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_waddr <= w_next_wa;
                        r_state <= w_next_in ? MEM_RD : FILL;
                        r_req   <= w_next_in;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || status_clr) begin
            r_bad   <= 1'b0;
            r_tmo   <= 1'b0;
            r_oow   <= 1'b0;
            r_beats <= '0;
        end else begin
            if (w_accept && w_bad)       r_bad   <= 1'b1;
            if (r_state == MEM_RD && w_tmo) r_tmo <= 1'b1;
            if (r_state == FILL)         r_oow   <= 1'b1;
            if (r_rddvld)                r_beats <= r_beats + 16'd1;
        end
    end

    assign avmm_slv_rddata = r_rddata;
    assign avmm_slv_rddvld = r_rddvld;
    assign mem_rd_req      = r_req;
    assign mem_rd_addr     = r_waddr;
    assign rsp_status      = {r_beats, 12'd0, r_oow, r_tmo, r_bad, (r_state != IDLE)};
endmodule

// File: tb/tb_pxeboot_flash_rdrsp.sv
// Bench for pxeboot_flash_rdrsp: table of bursts plus random bursts against a window/fill
// model, and hand sequences for clear priority, reset mid-burst and ack timeout.
module tb_pxeboot_flash_rdrsp;
    localparam logic [31:0] WIN       = 32'h0B80_0000;
    localparam longint      WIN_BYTES = 32 * 1024;
    localparam logic [31:0] NONE      = 32'hFFFF_FFFF;

    logic        clk = 1'b0, reset = 1'b1;
    logic [27:0] avmm_slv_addr = '0;
    logic        avmm_slv_read = 1'b0;
    logic [6:0]  avmm_slv_burstcnt = '0;
    logic [31:0] avmm_slv_rddata;
    logic        avmm_slv_rddvld, avmm_slv_waitreq, mem_rd_req;
    logic [25:0] mem_rd_addr;
    logic        mem_rd_ack = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic        status_clr = 1'b0;
    logic [31:0] rsp_status;

    pxeboot_flash_rdrsp #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .avmm_slv_addr(avmm_slv_addr), .avmm_slv_read(avmm_slv_read),
        .avmm_slv_burstcnt(avmm_slv_burstcnt), .avmm_slv_rddata(avmm_slv_rddata),
        .avmm_slv_rddvld(avmm_slv_rddvld), .avmm_slv_waitreq(avmm_slv_waitreq),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .status_clr(status_clr), .rsp_status(rsp_status));

    always #5 clk = ~clk;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: random latency per word, data = word address, optional stray acks.
    int          lat_lo = 0, lat_hi = 0;
    bit          stray_en = 1'b0;
    logic [31:0] noack_wa = NONE;
    bit          pend = 1'b0;
    int unsigned want = 0, wcnt = 0, txn_cnt = 0, stab_err = 0;
    logic [25:0] held = '0;
    always @(negedge clk) begin
        if (reset || !mem_rd_req) begin
            pend = 1'b0;
            mem_rd_ack  = stray_en & ~reset;
            mem_rd_data = 32'hDEAD_BEEF;
        end else begin
            if (pend && mem_rd_addr != held) stab_err++;
            if (!pend) begin
                pend = 1'b1; held = mem_rd_addr; wcnt = 0;
                want = $urandom_range(lat_hi, lat_lo);
            end
            if (wcnt >= want && 32'(mem_rd_addr) != noack_wa) begin
                mem_rd_ack = 1'b1; mem_rd_data = 32'(mem_rd_addr); pend = 1'b0; txn_cnt++;
            end else begin
                mem_rd_ack = 1'b0; wcnt++;
            end
        end
    end

    typedef struct { logic [31:0] d; int unsigned c; logic wr; } beat_t;
    beat_t mon_q[$];
    always @(negedge clk) if (avmm_slv_rddvld) mon_q.push_back('{avmm_slv_rddata, cyc, avmm_slv_waitreq});

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    // Reference: a word is real data when its byte address lies inside [WIN, WIN+32K).
    function automatic bit in_win(input logic [31:0] wa);
        longint b;
        b = longint'(wa) * 4;
        return (b >= longint'(WIN)) && (b < longint'(WIN) + WIN_BYTES);
    endfunction

    task automatic issue(input logic [31:0] addr, input logic [6:0] bc, output int unsigned t);
        int k = 0;
        while (avmm_slv_waitreq && k < 500) begin tick(); k++; end
        if (k >= 500) chk("waitreq_release_bound", 1, 0);
        avmm_slv_addr = addr[27:0]; avmm_slv_burstcnt = bc; avmm_slv_read = 1'b1;
        t = cyc;
        tick();
        avmm_slv_read = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (mon_q.size() < n && k < budget) begin tick(); k++; end
        if (k >= budget) chk("beat_wait_bound", mon_q.size(), n);
    endtask

    task automatic pulse_clr();
        status_clr = 1'b1; tick(); status_clr = 1'b0;
    endtask

    task automatic run_burst(input logic [31:0] addr, input logic [6:0] bc, input int lo, input int hi,
                             input bit stray, input logic [31:0] tmo_wa, output int nfill, output int ntxn);
        logic [31:0] exp_q[$];
        logic [31:0] wa;
        int eff, base, tbase;
        int unsigned t;
        eff = (bc == 0) ? 1 : (bc > 64) ? 64 : int'(bc);
        for (int i = 0; i < eff; i++) begin
            wa = ((addr >> 2) + i) & 32'h03FF_FFFF;
`ifdef PXEBOOT_FLASH_RDRSP_TIMEOUT_EN
            exp_q.push_back((!in_win(wa) || wa == tmo_wa) ? 32'hFFFF_FFFF : wa);
`else
            exp_q.push_back(!in_win(wa) ? 32'hFFFF_FFFF : wa);
`endif
        end
        lat_lo = lo; lat_hi = hi; stray_en = stray; noack_wa = tmo_wa;
        base = mon_q.size(); tbase = int'(txn_cnt);
        issue(addr, bc, t);
        wait_beats(base + eff, 3000);
        nfill = 0;
        for (int i = 0; i < eff && base + i < mon_q.size(); i++) begin
            chk($sformatf("beat_data[%0d]@%0h", i, addr), mon_q[base+i].d, exp_q[i]);
            chk($sformatf("beat_waitreq[%0d]", i), mon_q[base+i].wr, (i != eff - 1));
            if (hi == 0) chk($sformatf("beat_cycle[%0d]", i), mon_q[base+i].c, t + 2 + i);
            if (mon_q[base+i].d == 32'hFFFF_FFFF) nfill++;
        end
        repeat (3) tick();
        chk("beat_count", mon_q.size() - base, eff);
        ntxn = int'(txn_cnt) - tbase;
        stray_en = 1'b0; noack_wa = NONE;
    endtask

    typedef struct {
        logic [31:0] addr; logic [6:0] bc; int lo; int hi; bit stray;
        int exp_beats; int exp_fill; int exp_txn; bit exp_bad;
    } vec_t;

    initial begin
        vec_t vt[8];
        int nfill, ntxn, base;
        int unsigned t;
        logic [31:0] wa0, a;
        vt[0] = '{32'h0B80_0000, 7'd64,  0, 0, 1'b0, 64, 0, 64, 1'b0};
        vt[1] = '{32'h0B80_0100, 7'd8,   1, 7, 1'b0,  8, 0,  8, 1'b0};
        vt[2] = '{32'h0B80_7FF8, 7'd4,   0, 3, 1'b1,  4, 2,  2, 1'b0};
        vt[3] = '{32'h0B80_0000, 7'd0,   0, 2, 1'b0,  1, 0,  1, 1'b1};
        vt[4] = '{32'h0B80_0040, 7'd100, 0, 1, 1'b0, 64, 0, 64, 1'b1};
        vt[5] = '{32'h0000_1000, 7'd3,   0, 0, 1'b1,  3, 3,  0, 1'b0};
        vt[6] = '{32'h0FFF_FFFC, 7'd2,   0, 0, 1'b0,  2, 2,  0, 1'b0};
        vt[7] = '{32'h0B7F_FFF8, 7'd4,   0, 0, 1'b1,  4, 2,  2, 1'b0};

        // Reset state
        tick(); chk("waitreq_in_reset", avmm_slv_waitreq, 1);
        tick(); tick(); reset = 1'b0; #1;
        chk("rst_rddvld", avmm_slv_rddvld, 0); chk("rst_rddata", avmm_slv_rddata, 0);
        chk("rst_req", mem_rd_req, 0);         chk("rst_addr", mem_rd_addr, 0);
        chk("rst_status", rsp_status, 0);      chk("rst_waitreq_after", avmm_slv_waitreq, 0);

        for (int v = 0; v < 8; v++) begin
            pulse_clr();
            chk("status_after_clr", rsp_status, 0);
            run_burst(vt[v].addr, vt[v].bc, vt[v].lo, vt[v].hi, vt[v].stray, NONE, nfill, ntxn);
            chk($sformatf("v%0d_fill", v), nfill, vt[v].exp_fill);
            chk($sformatf("v%0d_txn", v), ntxn, vt[v].exp_txn);
            chk($sformatf("v%0d_busy", v), rsp_status[0], 0);
            chk($sformatf("v%0d_bad", v), rsp_status[1], vt[v].exp_bad);
            chk($sformatf("v%0d_tmo", v), rsp_status[2], 0);
            chk($sformatf("v%0d_oow", v), rsp_status[3], vt[v].exp_fill > 0);
            chk($sformatf("v%0d_beats", v), rsp_status[31:16], vt[v].exp_beats);
        end

        // status_clr on the first fill beat beats both the increment and the sticky set
        pulse_clr();
        lat_lo = 0; lat_hi = 0;
        base = mon_q.size();
        issue(32'h0000_2000, 7'd4, t);
        wait_beats(base + 1, 50);
        pulse_clr();
        wait_beats(base + 4, 50);
        repeat (2) tick();
        chk("clr_prio_beats", rsp_status[31:16], 3);
        chk("clr_prio_oow", rsp_status[3], 1);

        // Reset mid-burst
        base = mon_q.size();
        issue(32'h0B80_0000, 7'd64, t);
        wait_beats(base + 10, 200);
        reset = 1'b1; #1;
        chk("midrst_waitreq", avmm_slv_waitreq, 1);
        tick(); chk("midrst_waitreq2", avmm_slv_waitreq, 1);
        chk("midrst_req", mem_rd_req, 0);
        tick(); reset = 1'b0;
        repeat (5) tick();
        chk("midrst_beats", mon_q.size() - base, 10);
        chk("midrst_status", rsp_status, 0);
        run_burst(32'h0B80_0080, 7'd5, 0, 1, 1'b0, NONE, nfill, ntxn);
        chk("postrst_fill", nfill, 0);
        chk("postrst_beats", rsp_status[31:16], 5);

        // Ack timeout on word 3 of 4
        pulse_clr();
        wa0 = 32'h0B80_0200 >> 2;
`ifdef PXEBOOT_FLASH_RDRSP_TIMEOUT_EN
        run_burst(32'h0B80_0200, 7'd4, 0, 1, 1'b0, wa0 + 2, nfill, ntxn);
        chk("tmo_flag", rsp_status[2], 1);
        chk("tmo_oow", rsp_status[3], 0);
        chk("tmo_fill", nfill, 1);
        chk("tmo_txn", ntxn, 3);
`else
        lat_lo = 0; lat_hi = 1; noack_wa = wa0 + 2;
        base = mon_q.size();
        issue(32'h0B80_0200, 7'd4, t);
        wait_beats(base + 2, 100);
        repeat (40) tick();
        chk("stall_beats", mon_q.size() - base, 2);
        chk("stall_req", mem_rd_req, 1);
        chk("stall_addr", mem_rd_addr, wa0 + 2);
        chk("stall_tmo", rsp_status[2], 0);
        chk("stall_busy", rsp_status[0], 1);
        noack_wa = NONE;
        wait_beats(base + 4, 100);
        if (mon_q.size() >= base + 4) begin
            chk("stall_d2", mon_q[base+2].d, wa0 + 2);
            chk("stall_d3", mon_q[base+3].d, wa0 + 3);
        end
        repeat (2) tick();
        chk("stall_tmo_end", rsp_status[2], 0);
`endif

        // Random bursts around both window edges
        for (int r = 0; r < 20; r++) begin
            pulse_clr();
            a = ($urandom_range(0, 1) != 0) ? (WIN - 32'd64) : (WIN + 32'(WIN_BYTES) - 32'd64);
            a = a + 32'($urandom_range(0, 31)) * 4;
            t = $urandom_range(1, 40);
            run_burst(a, 7'(t), 0, $urandom_range(0, 4), $urandom_range(0, 1) != 0, NONE, nfill, ntxn);
            chk($sformatf("rnd%0d_beats", r), rsp_status[31:16], t);
            chk($sformatf("rnd%0d_oow", r), rsp_status[3], nfill > 0);
            chk($sformatf("rnd%0d_txn", r), ntxn, int'(t) - nfill);
        end

        chk("addr_stable", stab_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
